// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the HI/LO pair for the multicycle MIPS core.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, with start/busy/done handshake.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIN
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic                 neg_q, neg_d;
    logic                 rneg_q, rneg_d;
    logic                 is_div_q, is_div_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 dbz_q, dbz_d;
    logic                 dbz_pend_q, dbz_pend_d;

    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     rem;
    logic                 sgn;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            neg_q      <= 1'b0;
            rneg_q     <= 1'b0;
            is_div_q   <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            dbz_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            neg_q      <= neg_d;
            rneg_q     <= rneg_d;
            is_div_q   <= is_div_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
            dbz_pend_q <= dbz_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        neg_d      = neg_q;
        rneg_d     = rneg_q;
        is_div_d   = is_div_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        dbz_d      = 1'b0;
        dbz_pend_d = 1'b0;

        sgn = ~op[0];

        // Multiply: upper half accumulates, lower half holds the multiplier shifting out LSB-first.
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        // Divide: upper half is the partial remainder, lower half the dividend turning into the quotient.
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, mcand_q};

        prod = neg_q ? (~acc_q + 1'b1) : acc_q;
        quo  = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        rem  = rneg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

        case (state_q)
            IDLE: begin
                if (dbz_pend_q) begin
                    done_d = 1'b1;
                    dbz_d  = 1'b1;
                end
                if (start) begin
                    if (!op[1]) begin
                        mcand_d  = sgn ? mag(a) : a;
                        acc_d    = {{WIDTH{1'b0}}, (sgn ? mag(b) : b)};
                        neg_d    = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        rneg_d   = 1'b0;
                        is_div_d = 1'b0;
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = MUL;
                    end else if (b == '0) begin
                        dbz_pend_d = 1'b1;
                    end else begin
                        mcand_d  = sgn ? mag(b) : b;
                        acc_d    = {{WIDTH{1'b0}}, (sgn ? mag(a) : a)};
                        neg_d    = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        rneg_d   = sgn & a[WIDTH-1];
                        is_div_d = 1'b1;
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = DIV;
                    end
                end else begin
                    if (hi_wr) hi_d = wr_data;
                    if (lo_wr) lo_d = wr_data;
                end
            end
            MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) state_d = FIN;
            end
            DIV: begin
                if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                else                  acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) state_d = FIN;
            end
            FIN: begin
                if (is_div_q) begin
                    hi_d = rem;
                    lo_d = quo;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
